// File: rtl/dpram_port_ctrl_if.sv
// Command/response stream bundle for dpram_port_ctrl.
// Valid/ready handshake: a transfer happens on a posedge where valid & ready are both 1.
interface dpram_port_ctrl_if #(
   parameter int ADDR_W = 11
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_wr;
   logic              rsp_err;
   logic [7:0]        rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/dpram_port_ctrl.sv
// Request sequencer for one port of a dual-port RAM: accept -> issue -> wait -> capture into a
// credit-protected response FIFO. Optional statistics counters under DPRAM_PORT_CTRL_STATS_EN.
module dpram_port_ctrl #(
   parameter int ADDR_W    = 11,
   parameter int MEM_WORDS = 1025,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   dpram_port_ctrl_if.slave  bus,
   output logic [7:0]        mem_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wr_en,
   output logic              mem_chipselect,
   output logic              mem_outenable,
   input  logic [7:0]        mem_dataout
`ifdef DPRAM_PORT_CTRL_STATS_EN
   ,
   output logic [15:0]       stat_rd,
   output logic [15:0]       stat_wr,
   output logic [15:0]       stat_err
`endif
);
   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(MEM_WORDS);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);

   logic [CNT_W-1:0] credit;
   logic             acc;
   logic             pop;
   logic             push;
   logic             in_range;

   logic             i_vld, i_wr, i_err;
   logic             w_vld, w_wr, w_err;

   logic             f_wr   [RSP_DEPTH];
   logic             f_err  [RSP_DEPTH];
   logic [7:0]       f_data [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] f_cnt;

   // Credits cover every command from accept until its response is popped, so the FIFO can't overflow.
   assign bus.req_ready = (credit < DEPTH_C) & ~reset;
   assign acc           = bus.req_valid & bus.req_ready;
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign push          = w_vld;
   assign in_range      = {1'b0, bus.req_addr} < ADDR_LIM;

   always_ff @(posedge clk) begin
      if (reset) begin
         credit         <= '0;
         i_vld          <= 1'b0;
         i_wr           <= 1'b0;
         i_err          <= 1'b0;
         w_vld          <= 1'b0;
         w_wr           <= 1'b0;
         w_err          <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_wr_en      <= 1'b0;
         mem_outenable  <= 1'b0;
         mem_address    <= '0;
         mem_data       <= '0;
      end else begin
         credit         <= credit + CNT_W'(acc) - CNT_W'(pop);
         i_vld          <= acc;
         i_wr           <= bus.req_wr;
         i_err          <= ~in_range;
         mem_chipselect <= acc & in_range;
         mem_wr_en      <= acc & in_range & bus.req_wr;
         mem_outenable  <= acc & in_range & ~bus.req_wr;
         if (acc & in_range)
            mem_address <= bus.req_addr;
         if (acc & in_range & bus.req_wr)
            mem_data    <= bus.req_wdata;
         w_vld          <= i_vld;
         w_wr           <= i_wr;
         w_err          <= i_err;
      end
   end

   // The RAM registers dataout during W, so the capture stage sees the read result directly.
   always_ff @(posedge clk) begin
      if (push) begin
         f_wr[wr_ptr]   <= w_wr;
         f_err[wr_ptr]  <= w_err;
         f_data[wr_ptr] <= (w_wr | w_err) ? 8'h00 : mem_dataout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         f_cnt  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         f_cnt <= f_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign bus.rsp_valid = (f_cnt != '0);
   assign bus.rsp_wr    = bus.rsp_valid & f_wr[rd_ptr];
   assign bus.rsp_err   = bus.rsp_valid & f_err[rd_ptr];
   assign bus.rsp_rdata = bus.rsp_valid ? f_data[rd_ptr] : 8'h00;

`ifdef DPRAM_PORT_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_rd  <= '0;
         stat_wr  <= '0;
         stat_err <= '0;
      end else begin
         if (mem_chipselect & mem_outenable & (stat_rd != 16'hFFFF))
            stat_rd <= stat_rd + 16'd1;
         if (mem_chipselect & mem_wr_en & (stat_wr != 16'hFFFF))
            stat_wr <= stat_wr + 16'd1;
         if (i_vld & i_err & (stat_err != 16'hFFFF))
            stat_err <= stat_err + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Directed bench for dpram_port_ctrl with a behavioural registered-output RAM and an in-order scoreboard.
`timescale 1ns/1ps
module tb_dpram_port_ctrl;
   localparam int ADDR_W    = 11;
   localparam int MEM_WORDS = 1025;
   localparam int RSP_DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]        mem_data;
   logic [7:0]        mem_dataout;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wr_en, mem_chipselect, mem_outenable;
`ifdef DPRAM_PORT_CTRL_STATS_EN
   logic [15:0]       stat_rd, stat_wr, stat_err;
`endif

   dpram_port_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dpram_port_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus.slave),
      .mem_data       (mem_data),
      .mem_address    (mem_address),
      .mem_wr_en      (mem_wr_en),
      .mem_chipselect (mem_chipselect),
      .mem_outenable  (mem_outenable),
      .mem_dataout    (mem_dataout)
`ifdef DPRAM_PORT_CTRL_STATS_EN
      ,
      .stat_rd        (stat_rd),
      .stat_wr        (stat_wr),
      .stat_err       (stat_err)
`endif
   );

   // RAM port model: write and registered read on the same clock
   logic [7:0] ram [0:(1<<ADDR_W)-1];
   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
      mem_dataout = 8'h00;
   end
   always @(posedge clk) begin
      if (mem_chipselect & mem_wr_en) ram[mem_address] <= mem_data;
      if (mem_chipselect & mem_outenable) mem_dataout <= ram[mem_address];
   end

   // ---------------- counters / check ----------------
   int vectors    = 0;
   int miscompares = 0;
   int stalls     = 0;
   int rsp_total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   // expected word = {rsp_wr, rsp_err, rsp_rdata}
   logic [9:0] exp_q[$];
   int         lat_q[$];
   logic [9:0] mon_e;
   int         mon_l;

   always @(negedge clk) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         rsp_total++;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got %0h expected none", {bus.rsp_wr, bus.rsp_err, bus.rsp_rdata});
         end else begin
            mon_e = exp_q.pop_front();
            mon_l = lat_q.pop_front();
            check("rsp_payload", {22'd0, bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}, {22'd0, mon_e});
            if (mon_l >= 0) check("rsp_latency", cyc, mon_l);
         end
      end
   end

   logic watch_cs = 1'b0;
   logic cs_seen  = 1'b0;
   always @(negedge clk) if (watch_cs && mem_chipselect) cs_seen = 1'b1;

   // ---------------- driver tasks ----------------
   task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [7:0] wd,
                       input logic [9:0] exp, input bit chk_lat);
      bit done = 0;
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (bus.req_ready) done = 1;
         else stalls++;
         @(posedge clk);
      end
      #1;
      bus.req_valid = 1'b0;
      if (done) begin
         exp_q.push_back(exp);
         // accept edge A -> response visible in the cycle after edge A+2
         lat_q.push_back(chk_lat ? cyc + 2 : -1);
      end else begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got no accept expected accept addr %0d", addr);
      end
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(posedge clk);
         if (exp_q.size() == 0) done = 1;
      end
      #1;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_fields", {bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}, 0);
      check("rst_mem_strobes", {mem_chipselect, mem_wr_en, mem_outenable}, 0);
      check("rst_mem_addr_data", {mem_address, mem_data}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", bus.req_ready, 1);

      // write then back-to-back read of the same address
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      send(1'b1, 11'd5, 8'hA5, {1'b1, 1'b0, 8'h00}, 1'b1);
      send(1'b0, 11'd5, 8'h00, {1'b0, 1'b0, 8'hA5}, 1'b1);
      wait_drain();

      // out-of-range read and write never touch the RAM
      cs_seen  = 1'b0;
      watch_cs = 1'b1;
      send(1'b0, 11'd1025, 8'h00, {1'b0, 1'b1, 8'h00}, 1'b1);
      send(1'b1, 11'd2000, 8'h77, {1'b1, 1'b1, 8'h00}, 1'b1);
      wait_drain();
      watch_cs = 1'b0;
      check("err_no_chipselect", cs_seen, 0);

      // streaming 16 writes then 16 reads
      stalls = 0;
      for (int i = 0; i < 16; i++)
         send(1'b1, 11'(i), 8'(i * 17), {1'b1, 1'b0, 8'h00}, 1'b1);
      for (int i = 0; i < 16; i++)
         send(1'b0, 11'(i), 8'h00, {1'b0, 1'b0, 8'(i * 17)}, 1'b1);
      check("stream_no_stall", stalls, 0);
      wait_drain();

      // back-pressure: 4 reads fill credits, the 5th waits
      bus.rsp_ready = 1'b0;
      for (int i = 1; i <= 4; i++)
         send(1'b0, 11'(i), 8'h00, {1'b0, 1'b0, 8'(i * 17)}, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 11'd5;
      repeat (3) begin
         @(negedge clk);
         check("full_req_ready", bus.req_ready, 0);
         check("stall_payload", {bus.rsp_valid, bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}, {3'b100, 8'h11});
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      send(1'b0, 11'd5, 8'h00, {1'b0, 1'b0, 8'h55}, 1'b0);
      send(1'b0, 11'd6, 8'h00, {1'b0, 1'b0, 8'h66}, 1'b0);
      wait_drain();

      // reset with two reads in flight
      send(1'b0, 11'd1, 8'h00, {1'b0, 1'b0, 8'h11}, 1'b1);
      send(1'b0, 11'd2, 8'h00, {1'b0, 1'b0, 8'h22}, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("in_reset_req_ready", bus.req_ready, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      lat_q.delete();
      rsp_total = 0;
      @(negedge clk);
      check("flush_req_ready", bus.req_ready, 1);
      check("flush_rsp", {bus.rsp_valid, bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}, 0);
      check("flush_mem", {mem_chipselect, mem_wr_en, mem_outenable, mem_address, mem_data}, 0);
      repeat (6) @(negedge clk);
      check("flush_no_rsp", rsp_total, 0);

`ifdef DPRAM_PORT_CTRL_STATS_EN
      @(posedge clk); #1;
      send(1'b1, 11'd20, 8'h3C, {1'b1, 1'b0, 8'h00}, 1'b1);
      send(1'b1, 11'd21, 8'h4D, {1'b1, 1'b0, 8'h00}, 1'b1);
      send(1'b1, 11'd22, 8'h5E, {1'b1, 1'b0, 8'h00}, 1'b1);
      send(1'b0, 11'd20, 8'h00, {1'b0, 1'b0, 8'h3C}, 1'b1);
      send(1'b0, 11'd21, 8'h00, {1'b0, 1'b0, 8'h4D}, 1'b1);
      send(1'b0, 11'd1500, 8'h00, {1'b0, 1'b1, 8'h00}, 1'b1);
      wait_drain();
      check("stat_wr", stat_wr, 3);
      check("stat_rd", stat_rd, 2);
      check("stat_err", stat_err, 1);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
